// File: rtl/cmd_encoder.sv
// ============================================================================
// Module   : cmd_encoder
// Brief    : Turns word-level configuration requests into the XC parser's
//            8-bit command byte stream, with NOP bytes between commands.
//            Optional line-prefix cache: define CMD_ENCODER_LINE_CACHE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_encoder #(
    parameter int NUM_INPUTS = 8,
    parameter int GAP        = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [7:0]  req_line,
    input  logic [11:0] req_data,
    output logic [7:0]  cmd,
    output logic        cmd_strobe,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] c_OP_CLEAR   = 4'd0;
    localparam logic [3:0] c_OP_LINE    = 4'd1;
    localparam logic [3:0] c_OP_LEDS    = 4'd2;
    localparam logic [3:0] c_OP_BAUD    = 4'd3;
    localparam logic [3:0] c_OP_DLY_X   = 4'd4;
    localparam logic [3:0] c_OP_DLY_A   = 4'd5;
    localparam logic [3:0] c_OP_FREQ    = 4'd8;
    localparam logic [3:0] c_OP_VOLT    = 4'd9;
    localparam logic [3:0] c_OP_TEST    = 4'd12;
    localparam logic [3:0] c_OP_CAPTURE = 4'd13;

    localparam logic [7:0] c_NOP    = 8'h0F;
    localparam logic [8:0] c_NUM_IN = 9'(NUM_INPUTS);

    localparam int              c_GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PREFIX = 2'd1;
    localparam logic [1:0] S_BODY   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      r_k;
    logic            r_gap_body;
    logic [c_GW-1:0] r_gap_cnt;
    logic [3:0]      r_op;
    logic [7:0]      r_line;
    logic [11:0]     r_data;
    logic            r_err;

    logic            w_accept;
    logic            w_req_per_line;
    logic            w_req_global;
    logic            w_req_line_ok;
    logic            w_req_bad;
    logic            w_cache_hit;
    logic [1:0]      w_start_state;
    logic            w_from_body;
    logic            w_is_delay;
    logic [1:0]      w_adv_state;
    logic [1:0]      w_adv_k;
    logic [1:0]      w_line_pair;
    logic [2:0]      w_dly;
    logic [7:0]      w_cmd;
    logic            w_strobe;

    // ------------------------------------------------------------------
    // Request classification (evaluated on the raw request fields)
    // ------------------------------------------------------------------
    always_comb begin
        w_req_per_line = 1'b0;
        w_req_global   = 1'b0;
        case (req_op)
            c_OP_CLEAR, c_OP_LEDS, c_OP_DLY_X, c_OP_DLY_A, c_OP_VOLT, c_OP_TEST:
                w_req_per_line = 1'b1;
            c_OP_BAUD, c_OP_FREQ, c_OP_CAPTURE:
                w_req_global = 1'b1;
            default: ;
        endcase
    end

    assign w_accept      = req_valid && (r_state == S_IDLE);
    assign w_req_line_ok = ({1'b0, req_line} < c_NUM_IN);
    assign w_req_bad     = !(w_req_global ||
                             ((w_req_per_line || (req_op == c_OP_LINE)) && w_req_line_ok));

    always_comb begin
        w_start_state = S_BODY;
        if ((req_op == c_OP_LINE) || (w_req_per_line && !w_cache_hit)) begin
            w_start_state = S_PREFIX;
        end
    end

`ifdef CMD_ENCODER_LINE_CACHE_EN
    logic       r_cache_vld;
    logic [7:0] r_cache_line;

    assign w_cache_hit = r_cache_vld && (r_cache_line == req_line);

    // Shadow follows every LINE prefix the parser is sent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cache_vld  <= 1'b0;
            r_cache_line <= 8'h00;
        end else if (w_accept && !w_req_bad && (w_start_state == S_PREFIX)) begin
            r_cache_vld  <= 1'b1;
            r_cache_line <= req_line;
        end
    end
`else
    assign w_cache_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencing: which byte follows the one just emitted
    // ------------------------------------------------------------------
    assign w_is_delay  = (r_op == c_OP_DLY_X) || (r_op == c_OP_DLY_A);
    assign w_from_body = (r_state == S_BODY) || ((r_state == S_GAP) && r_gap_body);

    always_comb begin
        w_adv_state = S_IDLE;
        w_adv_k     = 2'd0;
        if (!w_from_body) begin
            if (r_k != 2'd3) begin
                w_adv_state = S_PREFIX;
                w_adv_k     = r_k + 2'd1;
            end else if (r_op != c_OP_LINE) begin
                w_adv_state = S_BODY;
            end
        end else if (w_is_delay && (r_k != 2'd3)) begin
            w_adv_state = S_BODY;
            w_adv_k     = r_k + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_k        <= 2'd0;
            r_gap_body <= 1'b0;
            r_gap_cnt  <= '0;
            r_op       <= 4'd0;
            r_line     <= 8'd0;
            r_data     <= 12'd0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_req_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= w_start_state;
                            r_k     <= 2'd0;
                            r_op    <= req_op;
                            r_line  <= req_line;
                            r_data  <= req_data;
                        end
                    end
                end
                S_PREFIX, S_BODY: begin
                    if (GAP == 0) begin
                        r_state <= w_adv_state;
                        r_k     <= w_adv_k;
                    end else begin
                        r_state    <= S_GAP;
                        r_gap_body <= (r_state == S_BODY);
                        r_gap_cnt  <= c_GAP_LAST;
                    end
                end
                default: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= w_adv_state;
                        r_k     <= w_adv_k;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte formatting for the byte state currently held
    // ------------------------------------------------------------------
    always_comb begin
        case (r_k)
            2'd0:    w_line_pair = r_line[1:0];
            2'd1:    w_line_pair = r_line[3:2];
            2'd2:    w_line_pair = r_line[5:4];
            default: w_line_pair = r_line[7:6];
        endcase
        case (r_k)
            2'd0:    w_dly = r_data[2:0];
            2'd1:    w_dly = r_data[5:3];
            2'd2:    w_dly = r_data[8:6];
            default: w_dly = r_data[11:9];
        endcase
    end

    always_comb begin
        w_cmd    = c_NOP;
        w_strobe = 1'b0;
        if (r_state == S_PREFIX) begin
            w_cmd    = {r_k, w_line_pair, 4'h1};
            w_strobe = 1'b1;
        end else if (r_state == S_BODY) begin
            w_strobe = 1'b1;
            case (r_op)
                c_OP_CLEAR:             w_cmd = 8'h00;
                c_OP_LEDS:              w_cmd = {r_data[3:0], 4'h2};
                c_OP_BAUD:              w_cmd = {r_data[3:0], 4'h3};
                c_OP_FREQ:              w_cmd = {r_data[3:0], 4'h8};
                c_OP_VOLT:              w_cmd = {r_data[3:0], 4'h9};
                c_OP_TEST:              w_cmd = {r_data[3:0], 4'hC};
                c_OP_CAPTURE:           w_cmd = {3'b000, r_data[0], 4'hD};
                c_OP_DLY_X, c_OP_DLY_A: w_cmd = {(r_op == c_OP_DLY_A), w_dly, 2'b01, r_k};
                default: begin
                    w_cmd    = c_NOP;
                    w_strobe = 1'b0;
                end
            endcase
        end
    end

    assign cmd        = w_cmd;
    assign cmd_strobe = w_strobe;
    assign busy       = (r_state != S_IDLE);
    assign req_ready  = (r_state == S_IDLE);
    assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cmd_encoder.sv
// Testbench for cmd_encoder: scenario tasks checked against a byte-list reference model.
`default_nettype none

module tb_cmd_encoder;
    localparam int NUM_INPUTS = 8;
    localparam int GAP        = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [7:0]  req_line;
    logic [11:0] req_data;
    logic [7:0]  cmd;
    logic        cmd_strobe;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    bit         m_cache_vld = 1'b0;
    int         m_cache_line = 0;
    logic [7:0] exp_q[$];
    bit         exp_ok;

    always #5 clk = ~clk;

    cmd_encoder #(.NUM_INPUTS(NUM_INPUTS), .GAP(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_line(req_line), .req_data(req_data),
        .cmd(cmd), .cmd_strobe(cmd_strobe), .busy(busy), .err(err)
    );

    function automatic bit is_per_line(int op);
        return op inside {0, 2, 4, 5, 9, 12};
    endfunction

    function automatic bit is_global(int op);
        return op inside {3, 8, 13};
    endfunction

    // Reference model: list of bytes the parser should receive for a request
    task automatic model_request(input int op, input int line, input int data);
        bit need_prefix;
        exp_q.delete();
        exp_ok = is_global(op) || ((is_per_line(op) || op == 1) && line < NUM_INPUTS);
        if (!exp_ok) return;
        need_prefix = (op == 1) || is_per_line(op);
`ifdef CMD_ENCODER_LINE_CACHE_EN
        if (is_per_line(op) && m_cache_vld && m_cache_line == line) need_prefix = 1'b0;
        if (need_prefix) begin
            m_cache_vld  = 1'b1;
            m_cache_line = line;
        end
`endif
        if (need_prefix)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(8'(k * 64 + ((line >> (2 * k)) % 4) * 16 + 1));
        case (op)
            0:  exp_q.push_back(8'h00);
            2:  exp_q.push_back(8'((data % 16) * 16 + 2));
            3:  exp_q.push_back(8'((data % 16) * 16 + 3));
            8:  exp_q.push_back(8'((data % 16) * 16 + 8));
            9:  exp_q.push_back(8'((data % 16) * 16 + 9));
            12: exp_q.push_back(8'((data % 16) * 16 + 12));
            13: exp_q.push_back(8'((data % 2) * 16 + 13));
            4, 5:
                for (int k = 0; k < 4; k++)
                    exp_q.push_back(8'((op == 5 ? 128 : 0) + ((data >> (3 * k)) % 8) * 16 + 4 + k));
            default: ;
        endcase
    endtask

    task automatic do_req(input int op, input int line, input int data, input string name);
        logic [7:0] got[$];
        int cycles = 0;
        bit want_strobe;
        model_request(op, line, data);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_before got=%b want=1", name, req_ready);
        end
        req_valid = 1'b1; req_op = 4'(op); req_line = 8'(line); req_data = 12'(data);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 4'($urandom); req_line = 8'($urandom); req_data = 12'($urandom);
        if (!exp_ok) begin
            total++;
            if (err !== 1'b1 || cmd_strobe !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s err_pulse got err=%b strobe=%b busy=%b ready=%b want 1 0 0 1",
                         name, err, cmd_strobe, busy, req_ready);
            end
            @(negedge clk);
            total++;
            if (err !== 1'b0) begin
                bad++; $display("FAIL %s err_width got=%b want=0", name, err);
            end
            return;
        end
        while (busy === 1'b1 && cycles < 64) begin
            cycles++;
            want_strobe = ((cycles - 1) % (GAP + 1)) == 0;
            total++;
            if (cmd_strobe !== want_strobe || (cmd_strobe === 1'b0 && cmd !== 8'h0F)) begin
                bad++;
                $display("FAIL %s cycle%0d got strobe=%b cmd=%h want strobe=%b",
                         name, cycles, cmd_strobe, cmd, want_strobe);
            end
            if (cmd_strobe === 1'b1) got.push_back(cmd);
            @(negedge clk);
        end
        total++;
        if (cycles != exp_q.size() * (1 + GAP)) begin
            bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, cycles, exp_q.size() * (1 + GAP));
        end
        total++;
        if (req_ready !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL %s ready_after got ready=%b err=%b want 1 0", name, req_ready, err);
        end
        total++;
        if (got.size() != exp_q.size()) begin
            bad++; $display("FAIL %s nbytes got=%0d want=%0d", name, got.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (got[i] !== exp_q[i]) begin
                    bad++; $display("FAIL %s byte%0d got=%h want=%h", name, i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_line = 8'd0; req_data = 12'd0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (cmd !== 8'h0F || cmd_strobe !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold got cmd=%h strobe=%b ready=%b busy=%b err=%b want 0f 0 1 0 0",
                         cmd, cmd_strobe, req_ready, busy, err);
            end
        end
        reset_n = 1'b1;
        m_cache_vld = 1'b0;
        @(negedge clk);
        total++;
        if (cmd !== 8'h0F || cmd_strobe !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release got cmd=%h strobe=%b ready=%b busy=%b", cmd, cmd_strobe, req_ready, busy);
        end
    endtask

    task automatic test_global();
        do_req(3, 0, 5, "baud");
        do_req(8, 6, 'hA7, "freq_div");
        do_req(13, 0, 3, "capture");
    endtask

    task automatic test_delay();
        do_req(5, 3, 'hABC, "delay_auto");
        do_req(4, 7, 'h5A3, "delay_cross");
        do_req(1, 5, 0, "line");
    endtask

    task automatic test_cache();
        do_req(9, 2, 7, "voltage_l2");
        do_req(12, 2, 1, "test_l2");
        do_req(2, 6, 9, "leds_l6");
    endtask

    task automatic test_errors();
        do_req(10, 0, 0, "bad_op");
        do_req(2, 8, 0, "bad_line");
        do_req(1, 200, 0, "bad_line_op");
        do_req(15, 0, 0, "op15");
    endtask

    task automatic test_reset_mid();
        int strobes = 0;
        int cyc = 0;
        int target;
        bit seen = 1'b0;
        model_request(5, 3, 'hABC);
        target = exp_q.size() - 1;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd5; req_line = 8'd3; req_data = 12'hABC;
        @(negedge clk);
        req_valid = 1'b0;
        while (strobes < target && cyc < 64) begin
            if (cmd_strobe === 1'b1) strobes++;
            if (strobes < target) begin
                @(negedge clk);
                cyc++;
            end
        end
        total++;
        if (strobes != target) begin
            bad++; $display("FAIL mid_reach got=%0d want=%0d", strobes, target);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (cmd !== 8'h0F || cmd_strobe !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got cmd=%h strobe=%b busy=%b ready=%b want 0f 0 0 1", cmd, cmd_strobe, busy, req_ready);
        end
        m_cache_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (cmd_strobe === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL mid_quiet got activity=1 want=0");
        end
        do_req(9, 3, 4, "after_reset");
    endtask

    task automatic test_random();
        int op, line;
        int prev_line = 0;
        for (int n = 0; n < 30; n++) begin
            op   = int'($urandom_range(0, 15));
            line = ($urandom_range(0, 1) == 1) ? prev_line : int'($urandom_range(0, 9));
            do_req(op, line, int'($urandom_range(0, 4095)), "random");
            prev_line = line;
        end
    endtask

    initial begin
        test_reset();
        test_global();
        test_delay();
        test_cache();
        test_errors();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
